// File: rtl/rotor_angle_integrator.sv
`default_nettype none
// ============================================================================
// Module      : rotor_angle_integrator
// Description : Multi-channel sign-magnitude Q-format integrator. Each sample
//               is scaled by gain, then added to the selected channel's
//               accumulator. The result either saturates or wraps at limit.
//               A clear request zeroes every channel, one channel per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rotor_angle_integrator #(
    parameter int N    = 24,
    parameter int Q    = 12,
    parameter int CH   = 4,
    parameter int WRAP = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [$clog2(CH)-1:0]   in_ch,
    input  logic [N-1:0]            in_data,
    input  logic [N-1:0]            gain,
    input  logic [N-2:0]            limit,
    input  logic                    clear,
    output logic                    out_valid,
    output logic [$clog2(CH)-1:0]   out_ch,
    output logic [N-1:0]            out_data,
    output logic                    sat_flag
);

    localparam int   M       = N - 1;
    localparam int   CW      = $clog2(CH);
    localparam logic WRAP_EN = (WRAP != 0);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic            flush;
    logic            accept;

    // Input capture stage
    logic            s0_valid_q;
    logic [CW-1:0]   s0_ch_q;
    logic [N-1:0]    s0_data_q;
    logic [N-1:0]    s0_gain_q;

    // Product stage
    logic            s1_valid_q;
    logic [CW-1:0]   s1_ch_q;
    logic [M-1:0]    s1_mag_q;
    logic            s1_sign_q;
    logic            s1_sat_q;

    logic [N-1:0]    acc_q [CH];

    logic [2*M-1:0]  prod_full;
    logic [2*M-1:0]  prod_shift;
    logic            prod_ovf;
    logic [M-1:0]    prod_mag;
    logic            prod_sign;

    logic [N-1:0]    acc_rd;
    logic [N-1:0]    raw_sum;
    logic [N-1:0]    lim_n;
    logic [N-1:0]    twolim;
    logic [N-1:0]    wrap_n;
    logic            res_sign;
    logic [M-1:0]    res_mag;
    logic            res_sat;

    // FSM next-state: RUN accepts samples, CLEAR sweeps accumulators to zero
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        in_ready = (state_q == ST_RUN);
        flush    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                    flush   = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (idx_q == CW'(CH - 1)) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                idx_d   = '0;
            end
        endcase
    end

    // A clear request wins over a same-cycle sample
    assign accept = in_valid && in_ready && !clear;

    // FSM state and sweep index registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Capture accepted sample and its gain
    always_ff @(posedge clk) begin
        if (!reset) begin
            s0_valid_q <= 1'b0;
            s0_ch_q    <= '0;
            s0_data_q  <= '0;
            s0_gain_q  <= '0;
        end else begin
            s0_valid_q <= accept;
            if (accept) begin
                s0_ch_q   <= in_ch;
                s0_data_q <= in_data;
                s0_gain_q <= gain;
            end
        end
    end

    // Scaled product: magnitudes multiplied, realigned by Q, saturated to M bits
    always_comb begin
        prod_full  = (2*M)'(s0_data_q[M-1:0]) * (2*M)'(s0_gain_q[M-1:0]);
        prod_shift = prod_full >> Q;
        prod_ovf   = |prod_shift[2*M-1:M];
        prod_mag   = prod_ovf ? {M{1'b1}} : prod_shift[M-1:0];
        prod_sign  = (s0_data_q[N-1] ^ s0_gain_q[N-1]) && (prod_mag != '0);
    end

    // Product stage register
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_mag_q   <= '0;
            s1_sign_q  <= 1'b0;
            s1_sat_q   <= 1'b0;
        end else begin
            s1_valid_q <= s0_valid_q && !flush;
            s1_ch_q    <= s0_ch_q;
            s1_mag_q   <= prod_mag;
            s1_sign_q  <= prod_sign;
            s1_sat_q   <= prod_ovf;
        end
    end

    // Sign-magnitude add against the live accumulator, then limit handling.
    // The accumulator is read here, so a back-to-back sample to the same
    // channel always sees the value written on the previous edge.
    always_comb begin
        acc_rd   = acc_q[s1_ch_q];
        lim_n    = {1'b0, limit};
        twolim   = {limit, 1'b0};
        res_sat  = s1_sat_q;
        if (acc_rd[N-1] == s1_sign_q) begin
            raw_sum  = {1'b0, acc_rd[M-1:0]} + {1'b0, s1_mag_q};
            res_sign = acc_rd[N-1];
        end else if (acc_rd[M-1:0] >= s1_mag_q) begin
            raw_sum  = {1'b0, acc_rd[M-1:0] - s1_mag_q};
            res_sign = acc_rd[N-1];
        end else begin
            raw_sum  = {1'b0, s1_mag_q - acc_rd[M-1:0]};
            res_sign = s1_sign_q;
        end
        wrap_n = twolim - raw_sum;
        // raw_sum carries the add carry in its top bit, so a carry always
        // compares above limit
        if (raw_sum > lim_n) begin
            if (WRAP_EN && (raw_sum <= twolim)) begin
                res_mag  = wrap_n[M-1:0];
                res_sign = !res_sign;
            end else begin
                res_mag  = limit;
                res_sat  = 1'b1;
            end
        end else begin
            res_mag = raw_sum[M-1:0];
        end
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
    end

    // Accumulator bank: sweep-clear in CLEAR, write-back of stage-2 result in RUN
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CH; i++) begin
                acc_q[i] <= '0;
            end
        end else if (state_q == ST_CLEAR) begin
            acc_q[idx_q] <= '0;
        end else if (s1_valid_q && !flush) begin
            acc_q[s1_ch_q] <= {res_sign, res_mag};
        end
    end

    // Output register: all fields zero unless a stage-2 result is presented
    always_ff @(posedge clk) begin
        if (!reset || flush || !s1_valid_q) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            out_ch    <= s1_ch_q;
            out_data  <= {res_sign, res_mag};
            sat_flag  <= res_sat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rotor_angle_integrator.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotor_angle_integrator
// Description : Scoreboard bench for rotor_angle_integrator. One saturating
//               and one wrapping instance share the same stimulus; each has
//               its own queue of hand-computed expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotor_angle_integrator;

    localparam logic [23:0] G1 = 24'h001000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_ch;
    logic [23:0] in_data;
    logic [23:0] gain;
    logic [22:0] limit;
    logic        clear;

    logic        rdy_s, ov_s, sf_s;
    logic [1:0]  och_s;
    logic [23:0] od_s;
    logic        rdy_w, ov_w, sf_w;
    logic [1:0]  och_w;
    logic [23:0] od_w;

    logic [31:0] q_sat[$];
    logic [31:0] q_wrap[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    rotor_angle_integrator #(.N(24), .Q(12), .CH(4), .WRAP(0)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s),
        .in_ch(in_ch), .in_data(in_data), .gain(gain), .limit(limit),
        .clear(clear), .out_valid(ov_s), .out_ch(och_s), .out_data(od_s),
        .sat_flag(sf_s)
    );

    rotor_angle_integrator #(.N(24), .Q(12), .CH(4), .WRAP(1)) u_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w),
        .in_ch(in_ch), .in_data(in_data), .gain(gain), .limit(limit),
        .clear(clear), .out_valid(ov_w), .out_ch(och_w), .out_data(od_w),
        .sat_flag(sf_w)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops on every presented result, checks idle zeros otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            if (ov_s) begin
                if (q_sat.size() == 0) begin
                    cmp("sat_unexpected_out", {5'd0, och_s, od_s, sf_s}, 32'hFFFF_FFFF);
                end else begin
                    cmp("sat_out", {5'd0, och_s, od_s, sf_s}, q_sat.pop_front());
                end
            end else begin
                cmp("sat_idle_zero", {5'd0, och_s, od_s, sf_s}, 32'd0);
            end
            if (ov_w) begin
                if (q_wrap.size() == 0) begin
                    cmp("wrap_unexpected_out", {5'd0, och_w, od_w, sf_w}, 32'hFFFF_FFFF);
                end else begin
                    cmp("wrap_out", {5'd0, och_w, od_w, sf_w}, q_wrap.pop_front());
                end
            end else begin
                cmp("wrap_idle_zero", {5'd0, och_w, od_w, sf_w}, 32'd0);
            end
        end
    end

    // One sample per call; consecutive calls are back-to-back
    task automatic drive(input logic [1:0] ch, input logic [23:0] d, input logic [23:0] g,
                         input bit push,
                         input logic [23:0] es, input logic fs,
                         input logic [23:0] ew, input logic fw);
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = d;
        gain     = g;
        if (push) begin
            q_sat.push_back({5'd0, ch, es, fs});
            q_wrap.push_back({5'd0, ch, ew, fw});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic same(input logic [1:0] ch, input logic [23:0] d, input logic [23:0] e, input logic f);
        drive(ch, d, G1, 1'b1, e, f, e, f);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int zeros;
        bit seen_ready;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_ch    = 2'd0;
        in_data  = '0;
        gain     = '0;
        limit    = 23'h7FFFFF;
        clear    = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(2);
        reset = 1'b1;
        @(negedge clk);
        cmp("reset_ready_sat", {31'd0, rdy_s}, 32'd1);
        cmp("reset_ready_wrap", {31'd0, rdy_w}, 32'd1);

        // Ramp on ch0
        same(2'd0, 24'h000800, 24'h000800, 1'b0);
        same(2'd0, 24'h000800, 24'h001000, 1'b0);
        same(2'd0, 24'h000800, 24'h001800, 1'b0);
        same(2'd0, 24'h000800, 24'h002000, 1'b0);

        // Sign handling and no negative zero on ch1; ch0 untouched
        same(2'd1, 24'h000200, 24'h000200, 1'b0);
        same(2'd1, 24'h800400, 24'h800200, 1'b0);
        same(2'd1, 24'h000200, 24'h000000, 1'b0);
        same(2'd0, 24'h000000, 24'h002000, 1'b0);
        idle(4);

        // Limit behaviour with limit = 0x3000
        limit = 23'h003000;
        idle(1);
        same(2'd2, 24'h001000, 24'h001000, 1'b0);
        same(2'd2, 24'h001000, 24'h002000, 1'b0);
        same(2'd2, 24'h001000, 24'h003000, 1'b0);
        drive(2'd2, 24'h001000, G1, 1'b1, 24'h003000, 1'b1, 24'h802000, 1'b0);
        same(2'd3, 24'h002800, 24'h002800, 1'b0);
        drive(2'd3, 24'h001000, G1, 1'b1, 24'h003000, 1'b1, 24'h802800, 1'b0);
        // Beyond twice the limit both instances clamp
        same(2'd1, 24'h007000, 24'h003000, 1'b1);
        // Negative crossing: sum -0x4000
        drive(2'd1, 24'h807000, G1, 1'b1, 24'h803000, 1'b1, 24'h002000, 1'b0);
        idle(4);
        limit = 23'h7FFFFF;
        idle(1);

        // Clear with two samples in flight plus an ignored same-cycle sample
        drive(2'd0, 24'h001000, G1, 1'b0, '0, 1'b0, '0, 1'b0);
        drive(2'd1, 24'h001000, G1, 1'b0, '0, 1'b0, '0, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_ch    = 2'd2;
        in_data  = 24'h001000;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        zeros      = 0;
        seen_ready = 1'b0;
        for (int i = 0; i < 12 && !seen_ready; i++) begin
            @(negedge clk);
            if (rdy_s && rdy_w) seen_ready = 1'b1;
            else zeros++;
        end
        cmp("clear_ready_low_cycles", zeros, 32'd4);
        for (int c = 0; c < 4; c++) begin
            same(2'(c), 24'h000000, 24'h000000, 1'b0);
        end
        idle(4);

        // Product overflow
        drive(2'd0, 24'h7FFFFF, 24'h002000, 1'b1, 24'h7FFFFF, 1'b1, 24'h7FFFFF, 1'b1);
        same(2'd1, 24'h000100, 24'h000100, 1'b0);
        same(2'd2, 24'h000100, 24'h000100, 1'b0);

        // Reset mid-stream with two samples in flight
        drive(2'd3, 24'h001000, G1, 1'b0, '0, 1'b0, '0, 1'b0);
        drive(2'd0, 24'h001000, G1, 1'b0, '0, 1'b0, '0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        cmp("midreset_ready", {30'd0, rdy_s, rdy_w}, 32'd3);
        for (int c = 0; c < 4; c++) begin
            same(2'(c), 24'h000000, 24'h000000, 1'b0);
        end
        idle(3);

        // Reset overrides a clear sweep in progress
        same(2'd1, 24'h000300, 24'h000300, 1'b0);
        idle(3);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        idle(1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        cmp("sweep_reset_ready", {30'd0, rdy_s, rdy_w}, 32'd3);
        same(2'd1, 24'h000500, 24'h000500, 1'b0);
        idle(5);

        cmp("sat_queue_drained", q_sat.size(), 32'd0);
        cmp("wrap_queue_drained", q_wrap.size(), 32'd0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rotor_angle_integrator.md
ROTOR_ANGLE_INTEGRATOR -- requirements
Module: rotor_angle_integrator

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  N, 24, word width, sign-magnitude: bit N-1 sign, bits N-2:0 magnitude
  Q, 12, fractional bits of the magnitude
  CH, 4, number of independent accumulator channels (power of two, >=2)
  WRAP, 0, 0 = saturate at limit; 1 = wrap at +/-limit (angle mode)
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  clock
  reset  in  1  synchronous, active-low
  in_valid  in  1  sample present
  in_ready  out  1  block can accept a sample
  in_ch  in  log2(CH)  target channel
  in_data  in  N  increment, sign-magnitude Q-format
  gain  in  N  scale (Ts*k), sign-magnitude Q-format, sampled with in_data
  limit  in  N-1  magnitude bound, static while in_valid is high
  clear  in  1  one-cycle request to zero all channels
  out_valid  out  1  updated accumulator present, one cycle
  out_ch  out  log2(CH)  channel of out_data
  out_data  out  N  new accumulator value
  sat_flag  out  1  saturation or overflow occurred on this output
REQ-003 Reset is reset, synchronous, active-low; clock is clk.

Function
REQ-004 A sample SHALL be accepted on a rising clk edge where in_valid and in_ready are both 1.
REQ-005 Stage 1 (accept edge +1) SHALL register the product magnitude = (in_data[N-2:0]*gain[N-2:0]) >> Q; sign = XOR of the input signs.
REQ-006 If product bits above N-2 after the shift are nonzero, the magnitude SHALL saturate to all ones and sat_flag SHALL be set for that sample.
REQ-007 Stage 2 (accept edge +2) SHALL sign-magnitude-add the product to acc[ch], write the result back, and present out_valid=1 with out_ch and out_data.
REQ-008 Latency SHALL be 2 cycles; throughput SHALL be 1 sample/cycle, including back-to-back samples to the same channel (acc read in stage 2, no stale value).
REQ-009 Negative zero SHALL never appear: any zero magnitude SHALL have sign 0.
REQ-010 Magnitude-add carry out of bit N-2 SHALL be treated as magnitude > limit.
REQ-011 WRAP=0: if the sum magnitude > limit, the result SHALL be the sum sign with magnitude = limit, and sat_flag SHALL be 1.
REQ-012 WRAP=1: if limit < the sum magnitude <= 2*limit, the result SHALL be magnitude = 2*limit - sum magnitude with the sign inverted (zero forced positive), and sat_flag SHALL be 0.
REQ-013 WRAP=1: if the sum magnitude > 2*limit, the block SHALL clamp as in REQ-011 and set sat_flag=1.
REQ-014 The FSM SHALL have two states: RUN (in_ready=1) and CLEAR (in_ready=0).
REQ-015 In RUN, clear=1 SHALL transition to CLEAR, flush both pipeline stages (no out_valid for in-flight samples), and ignore a same-cycle in_valid.
REQ-016 In CLEAR, an index counter SHALL zero acc[idx] for idx = 0..CH-1, one per cycle; after CH cycles the FSM SHALL return to RUN.
REQ-017 clear asserted while in CLEAR SHALL be ignored.
REQ-018 out_valid, out_ch, out_data and sat_flag SHALL be 0 in every cycle without a stage-2 result.

Reset
REQ-019 reset=0 at a clk edge SHALL zero all acc[], both pipeline valids, idx and every output, and set the FSM to RUN, so in_ready=1 on the first cycle after release.
REQ-020 Reset mid-operation SHALL discard in-flight samples with no out_valid, and override a CLEAR sweep in progress.

Verification
REQ-021 Ramp: N=24, Q=12, gain=0x001000; send ch0 in_data=0x000800 four times back-to-back -> out_data 0x000800, 0x001000, 0x001800, 0x002000 on accept edges +2..+5.
REQ-022 Sign/zero: ch1 at 0x000200, in=0x800400 -> 0x800200; then in=0x000200 -> 0x000000 (not 0x800000); ch0 unaffected.
REQ-023 Saturate: WRAP=0, limit=0x003000, four times +0x001000 -> 0x001000, 0x002000, 0x003000 (sat 0), 0x003000 (sat 1).
REQ-024 Wrap: WRAP=1, limit=0x003000, acc=0x002800, in=+0x001000 -> 0x802800, sat_flag=0.
REQ-025 Overflow: in=0x7FFFFF, gain=0x002000, limit=0x7FFFFF, WRAP=0 -> out 0x7FFFFF, sat_flag=1.
REQ-026 Clear/reset: pulse clear with two samples in flight -> no out_valid for them, in_ready=0 for exactly CH=4 cycles, then every channel reads 0 on its next +0x000000 sample; repeat with reset=0 mid-stream -> identical result.
